// File: rtl/tr_pkg.sv
// Shared definitions for the TR timing generator and the blocks that consume its waveform.
package tr_pkg;

  localparam int CNT_W_DEF  = 24;
  localparam int FCNT_W_DEF = 16;

  // Receive/idle level of the TR strobe; the far-end filter relies on the same polarity.
  localparam logic TR_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    TX   = 2'd2,
    RX   = 2'd3
  } tr_state_e;

endpackage

// File: rtl/tr_gen_if.sv
// Configuration and waveform bundle between the TR generator and its controller.
interface tr_gen_if #(
  parameter int CNT_W  = tr_pkg::CNT_W_DEF,
  parameter int FCNT_W = tr_pkg::FCNT_W_DEF
);

  logic              enable;
  logic              single;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_lead;
  logic [CNT_W-1:0]  cfg_tx_width;
  logic              tr_out;
  logic              sw_en;
  logic              sof;
  logic              busy;
  logic              cfg_err;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output enable, single, cfg_period, cfg_lead, cfg_tx_width,
    input  tr_out, sw_en, sof, busy, cfg_err, frame_cnt
  );

  modport slave (
    input  enable, single, cfg_period, cfg_lead, cfg_tx_width,
    output tr_out, sw_en, sof, busy, cfg_err, frame_cnt
  );

endinterface

// File: rtl/tr_cfg_check.sv
// Combinational sanity check of a TR frame configuration; also usable for register read-back status.
module tr_cfg_check
  import tr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] lead,
  input  logic [CNT_W-1:0] tx_width,
  output logic             valid
);

  logic [CNT_W:0] active_len;

  // The extra bit makes a wrapped lead+width sum compare as too long rather than short.
  always_comb begin
    active_len = {1'b0, lead} + {1'b0, tx_width};
    valid      = (period != '0) && (tx_width != '0) && (active_len < {1'b0, period});
  end

endmodule

// File: rtl/tr_gen.sv
// TR strobe / RF switch pre-enable generator: LEAD -> TX -> RX frames with registered pin outputs.
module tr_gen
  import tr_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FCNT_W = FCNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  tr_gen_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  tr_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  sh_period;
  logic [CNT_W-1:0]  sh_lead;
  logic [CNT_W-1:0]  sh_width;
  logic              pending;
  logic              armed;
  logic              blocked;

  logic              tr_q;
  logic              sw_q;
  logic              sof_q;
  logic              busy_q;
  logic              err_q;
  logic [FCNT_W-1:0] fcnt_q;

  logic [CNT_W-1:0]  nx_period;
  logic [CNT_W-1:0]  nx_lead;
  logic [CNT_W-1:0]  nx_width;
  logic              nx_valid;
  tr_state_e         ent_state;
  logic [CNT_W-1:0]  ent_cnt;
  logic              ent_tr;

  // From IDLE the frame begins from the shadow copy taken a cycle earlier; a back-to-back
  // frame begins from the live config words being latched on that same edge.
  always_comb begin
    nx_period = bus.cfg_period;
    nx_lead   = bus.cfg_lead;
    nx_width  = bus.cfg_tx_width;
    if (state == IDLE) begin
      nx_period = sh_period;
      nx_lead   = sh_lead;
      nx_width  = sh_width;
    end
    ent_state = TX;
    ent_cnt   = nx_width - CNT_ONE;
    ent_tr    = ~TR_IDLE;
    if (nx_lead != '0) begin
      ent_state = LEAD;
      ent_cnt   = nx_lead - CNT_ONE;
      ent_tr    = TR_IDLE;
    end
  end

  tr_cfg_check #(
    .CNT_W (CNT_W)
  ) u_cfg_check (
    .period   (nx_period),
    .lead     (nx_lead),
    .tx_width (nx_width),
    .valid    (nx_valid)
  );

  // cnt holds the cycles remaining in the current state after this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_period <= '0;
      sh_lead   <= '0;
      sh_width  <= '0;
      pending   <= 1'b0;
      armed     <= 1'b0;
      blocked   <= 1'b0;
      tr_q      <= TR_IDLE;
      sw_q      <= 1'b0;
      sof_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      sof_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            if (nx_valid) begin
              state  <= ent_state;
              cnt    <= ent_cnt;
              tr_q   <= ent_tr;
              sw_q   <= 1'b1;
              sof_q  <= 1'b1;
              busy_q <= 1'b1;
            end else begin
              err_q   <= 1'b1;
              blocked <= 1'b1;
            end
          end else if (bus.enable && !blocked && (!bus.single || armed)) begin
            pending   <= 1'b1;
            armed     <= 1'b0;
            sh_period <= bus.cfg_period;
            sh_lead   <= bus.cfg_lead;
            sh_width  <= bus.cfg_tx_width;
          end
        end
        LEAD: begin
          if (cnt == '0) begin
            state <= TX;
            cnt   <= sh_width - CNT_ONE;
            tr_q  <= ~TR_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        TX: begin
          if (cnt == '0) begin
            state <= RX;
            cnt   <= sh_period - sh_lead - sh_width - CNT_ONE;
            tr_q  <= TR_IDLE;
            sw_q  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RX: begin
          if (cnt == '0) begin
            fcnt_q <= fcnt_q + FCNT_ONE;
            if (bus.enable && !bus.single) begin
              armed     <= 1'b0;
              sh_period <= bus.cfg_period;
              sh_lead   <= bus.cfg_lead;
              sh_width  <= bus.cfg_tx_width;
              if (nx_valid) begin
                state <= ent_state;
                cnt   <= ent_cnt;
                tr_q  <= ent_tr;
                sw_q  <= 1'b1;
                sof_q <= 1'b1;
              end else begin
                state   <= IDLE;
                err_q   <= 1'b1;
                blocked <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
      // Seeing enable low re-arms single-shot mode and clears a refused-start lockout.
      if (!bus.enable) begin
        armed   <= 1'b1;
        blocked <= 1'b0;
      end
    end
  end

  assign bus.tr_out    = tr_q;
  assign bus.sw_en     = sw_q;
  assign bus.sof       = sof_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_err   = err_q;
  assign bus.frame_cnt = fcnt_q;

endmodule

// File: tb/tb_tr_gen.sv
// Randomized scoreboard bench for tr_gen, checked against a frame-position reference model.
module tb_tr_gen;

  localparam int CW = 8;
  localparam int FW = 4;

  typedef struct packed {
    logic          tr;
    logic          sw;
    logic          sof;
    logic          busy;
    logic          err;
    logic [FW-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int dut_sof = 0;
  int dut_err = 0;
  int mdl_sof = 0;
  int mdl_err = 0;
  exp_t exp_q[$];

  tr_gen_if #(.CNT_W(CW), .FCNT_W(FW)) bus ();

  tr_gen #(.CNT_W(CW), .FCNT_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: tracks position within the current frame and derives outputs from it.
  int m_pos = -1;
  int m_per = 0;
  int m_lead = 0;
  int m_wid = 0;
  bit m_pend = 0;
  bit m_armed = 0;
  bit m_blocked = 0;
  int m_fcnt = 0;

  function automatic bit cfgOk(input int p, input int l, input int w);
    return (p != 0) && (w != 0) && (l + w < p);
  endfunction

  always @(posedge clk) begin
    bit en, sg, err;
    int p, l, w;
    exp_t e;
    en = bus.enable;
    sg = bus.single;
    p = int'(bus.cfg_period);
    l = int'(bus.cfg_lead);
    w = int'(bus.cfg_tx_width);
    err = 0;
    if (rst) begin
      m_pos = -1; m_pend = 0; m_armed = 0; m_blocked = 0; m_fcnt = 0;
    end else begin
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == m_per) begin
          m_fcnt = (m_fcnt + 1) % (1 << FW);
          m_pos = -1;
          if (en && !sg) begin
            m_per = p; m_lead = l; m_wid = w; m_armed = 0;
            if (cfgOk(p, l, w)) m_pos = 0;
            else begin err = 1; m_blocked = 1; end
          end
        end
      end else if (m_pend) begin
        m_pend = 0;
        if (cfgOk(m_per, m_lead, m_wid)) m_pos = 0;
        else begin err = 1; m_blocked = 1; end
      end else if (en && !m_blocked && (!sg || m_armed)) begin
        m_pend = 1; m_armed = 0; m_per = p; m_lead = l; m_wid = w;
      end
      if (!en) begin m_armed = 1; m_blocked = 0; end
    end
    e.err = err;
    e.fcnt = FW'(m_fcnt);
    if (m_pos >= 0) begin
      e.sof = (m_pos == 0);
      e.busy = 1'b1;
      e.sw = (m_pos < m_lead + m_wid);
      e.tr = !((m_pos >= m_lead) && (m_pos < m_lead + m_wid));
    end else begin
      e.sof = 1'b0; e.busy = 1'b0; e.sw = 1'b0; e.tr = 1'b1;
    end
    mdl_sof += int'(e.sof);
    mdl_err += int'(e.err);
    exp_q.push_back(e);
  end

  task automatic checkOutput(input exp_t e);
    exp_t got;
    got = '{bus.tr_out, bus.sw_en, bus.sof, bus.busy, bus.cfg_err, bus.frame_cnt};
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL outputs t=%0t got tr=%b sw=%b sof=%b busy=%b err=%b fcnt=%0d required tr=%b sw=%b sof=%b busy=%b err=%b fcnt=%0d",
               $time, got.tr, got.sw, got.sof, got.busy, got.err, got.fcnt,
               e.tr, e.sw, e.sof, e.busy, e.err, e.fcnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      dut_sof += int'(bus.sof === 1'b1);
      dut_err += int'(bus.cfg_err === 1'b1);
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic applyStimulus(input bit en, input bit sg, input int per, input int ld,
                               input int wd, input int cycles);
    bus.enable = en;
    bus.single = sg;
    bus.cfg_period = CW'(per);
    bus.cfg_lead = CW'(ld);
    bus.cfg_tx_width = CW'(wd);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.single = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_lead = '0;
    bus.cfg_tx_width = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] continuous frames, lead 2 width 3 period 10");
    applyStimulus(1, 0, 10, 2, 3, 31);
    applyStimulus(0, 0, 10, 2, 3, 12);
    $display("[TB] single shot, no lead");
    applyStimulus(1, 1, 8, 0, 4, 50);
    applyStimulus(0, 1, 8, 0, 4, 5);
    $display("[TB] refused configurations");
    applyStimulus(1, 0, 10, 2, 0, 10);
    applyStimulus(0, 0, 10, 2, 0, 3);
    applyStimulus(1, 0, 10, 5, 5, 10);
    applyStimulus(0, 0, 10, 5, 5, 3);
    applyStimulus(1, 0, 250, 200, 100, 6);
    applyStimulus(0, 0, 250, 200, 100, 3);
    applyStimulus(1, 0, 0, 0, 1, 6);
    applyStimulus(0, 0, 0, 0, 1, 3);
    $display("[TB] mid-frame width change and enable drop in TX");
    applyStimulus(1, 0, 10, 2, 3, 4);
    applyStimulus(1, 0, 10, 2, 6, 12);
    applyStimulus(0, 0, 10, 2, 6, 20);
    $display("[TB] reset during TX and restart");
    applyStimulus(1, 0, 10, 2, 5, 15);
    rst = 1'b1;
    applyStimulus(1, 0, 10, 2, 5, 1);
    rst = 1'b0;
    applyStimulus(0, 0, 10, 2, 5, 2);
    applyStimulus(1, 0, 10, 2, 5, 12);
    applyStimulus(0, 0, 10, 2, 5, 12);
    $display("[TB] frame counter wrap");
    applyStimulus(1, 0, 4, 0, 1, 80);
    applyStimulus(1, 0, 4, 1, 2, 12);
    applyStimulus(0, 0, 4, 1, 2, 6);
    $display("[TB] random traffic");
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      applyStimulus(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 16)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)), int'($urandom_range(1, 12)));
    end
    applyStimulus(0, 0, 10, 2, 3, 30);
    checks++;
    if (dut_sof != mdl_sof || mdl_sof == 0) begin
      failures++;
      $display("[TB] FAIL sof_count got=%0d required=%0d (nonzero)", dut_sof, mdl_sof);
    end
    checks++;
    if (dut_err != mdl_err || mdl_err == 0) begin
      failures++;
      $display("[TB] FAIL cfg_err_count got=%0d required=%0d (nonzero)", dut_err, mdl_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tr_gen.md
Name: tr_gen

Overview:
- Generates the transmit/receive (TR) timing waveform that the TR input filter receives on the far end.
- Produces a periodic, active-low TR strobe and an RF switch pre-enable, with programmable lead, transmit width and frame period.
- Sits in the timing-control path; configuration words come from the register/command block.
- All outputs are registered so they can drive pins directly.

Parameters:
- CNT_W, 24, width of the period/width/lead configuration words and of the internal cycle counter.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  run request; level-sensitive, sampled every cycle
- single  in  1  1 = one frame per enable assertion; 0 = continuous frames
- cfg_period  in  CNT_W  frame length in clk cycles
- cfg_lead  in  CNT_W  switch pre-enable cycles before TX; 0 allowed
- cfg_tx_width  in  CNT_W  TX (tr low) length in clk cycles
- tr_out  out  1  TR strobe: 1 = receive/idle, 0 = transmit
- sw_en  out  1  RF switch enable, high during LEAD and TX
- sof  out  1  one-cycle pulse on the first cycle of each frame
- busy  out  1  high while a frame is in progress
- cfg_err  out  1  one-cycle pulse when a frame start is refused
- frame_cnt  out  FCNT_W  count of completed frames

Behaviour:
- Reset, synchronous and active-high:
  - tr_out=1, sw_en=0, sof=0, busy=0, cfg_err=0, frame_cnt=0.
  - State returns to IDLE and the counter clears.
  - A reset mid-frame aborts the frame immediately; the next cycle shows reset values.
- States:
  - IDLE: tr_out=1, sw_en=0.
  - LEAD: tr_out=1, sw_en=1.
  - TX: tr_out=0, sw_en=1.
  - RX: tr_out=1, sw_en=0.
- Frame start:
  - A frame starts when the FSM is in IDLE with enable=1 (with single=1, also requires the armed flag; see below).
  - On a start, cfg_period, cfg_lead and cfg_tx_width are latched into shadow registers. Config changes mid-frame have no effect until the next frame start.
- Validity check on the latched values:
  - Valid requires cfg_period!=0, cfg_tx_width!=0, and cfg_lead+cfg_tx_width < cfg_period.
  - The sum is computed at CNT_W+1 bits, so overflow counts as invalid.
  - If invalid: pulse cfg_err for one cycle, stay in IDLE, and do not retry until enable drops and rises again.
- Latency: if enable is sampled high at edge N, the first LEAD (or TX) cycle and sof appear at the outputs after edge N+1.
- Frame sequence:
  - LEAD lasts exactly cfg_lead cycles; it is skipped when cfg_lead=0, going straight to TX.
  - TX lasts exactly cfg_tx_width cycles.
  - RX lasts cfg_period-cfg_lead-cfg_tx_width cycles (at least 1).
  - Total frame = cfg_period cycles exactly.
- sof:
  - High on the first cycle of every frame, whether LEAD or TX.
  - busy is high from that cycle through the last RX cycle.
- End of RX:
  - frame_cnt increments, wrapping at 2^FCNT_W-1 to 0.
  - If enable=1 and single=0, the next frame starts back-to-back with no IDLE gap. The config is re-latched and re-checked; if the check fails: cfg_err pulse, go to IDLE.
  - Otherwise go to IDLE.
- single=1:
  - Exactly one frame per rising edge of enable. An internal armed flag is set when enable=0 and cleared at frame start.
  - Holding enable high never causes a second frame.
- enable dropping mid-frame: the current frame completes unchanged. TX is never truncated and there are no runt pulses.
- Glitch-freedom: tr_out and sw_en change only on state transitions, and each comes straight from a flop.

Decomposition:
- Shared package (tr_pkg):
  - State encoding constants: IDLE, LEAD, TX, RX.
  - CNT_W and FCNT_W defaults.
  - TR_IDLE=1'b1, the TR polarity constant shared with the receiving filter.
- Sub-module: tr_cfg_check, purely combinational validity check on the latched config, reusable by the register block for read-back status.
- The FSM, counter and output flops stay in tr_gen.

Test Plan:
1. period=10, lead=2, width=3, single=0, enable held:
   - sw_en high 5 cycles, tr_out low 3 cycles starting 2 cycles after sof, sof every 10 cycles.
   - frame_cnt reads 3 after 30 cycles.
2. lead=0, width=4, period=8, single=1, enable held high for 50 cycles:
   - exactly one frame, TX begins on the sof cycle, busy falls after 8 cycles, frame_cnt=1.
3. Invalid config:
   - width=0 -> cfg_err single pulse, tr_out stays 1, busy stays 0.
   - lead=5, width=5, period=10 -> cfg_err.
   - No repeat cfg_err while enable stays high.
4. Change cfg_tx_width from 3 to 6 mid-frame:
   - current frame keeps a 3-cycle TX; the next frame has 6.
   - Deassert enable during TX: the frame finishes, then IDLE.
5. Assert rst during TX:
   - next cycle tr_out=1, sw_en=0, busy=0, frame_cnt=0.
   - Restart after rst release gives sof exactly one cycle after enable is sampled.
6. FCNT_W=4, period=4, continuous:
   - frame_cnt wraps from 15 to 0 with no gap in the sof cadence.
